// File: rtl/fb_arbiter.sv
// fb_arbiter: single-port framebuffer arbiter, priority scanout read > clear engine > writer.
// Optional macro WR_BLANK_ONLY_EN: writer and clear grants also require disp_blank=1.
module fb_arbiter #(
  parameter int unsigned       ADDR_W    = 14,
  parameter int unsigned       DATA_W    = 24,
  parameter int unsigned       DEPTH     = 10000,
  parameter logic [DATA_W-1:0] CLR_COLOR = DATA_W'(24'h000000)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_rvalid,
  input  logic              disp_blank,
  input  logic              wr_valid,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              err_oob,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0]   DEPTH_X   = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t            state;
  logic [ADDR_W-1:0] clr_addr;
  logic              rd_pend;
  logic              blank_ok;
  logic              clr_gnt;
  logic              wr_gnt;
  logic              wr_in_range;

`ifdef WR_BLANK_ONLY_EN
  assign blank_ok = disp_blank;
`else
  logic unused_blank;
  assign unused_blank = disp_blank;
  assign blank_ok     = 1'b1;
`endif

  // Grant decode: scanout always wins, then clear, then writer
  assign wr_ready    = (state == IDLE) && !disp_req && blank_ok;
  assign clr_gnt     = (state == CLEAR) && !disp_req && blank_ok;
  assign wr_gnt      = wr_valid && wr_ready;
  assign wr_in_range = {1'b0, wr_addr} < DEPTH_X;
  assign clr_busy    = (state == CLEAR);
  assign disp_rdata  = mem_rdata;

  // FSM, RAM port register and read-return pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      clr_addr    <= '0;
      rd_pend     <= 1'b0;
      disp_rvalid <= 1'b0;
      clr_done    <= 1'b0;
      err_oob     <= 1'b0;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      clr_done    <= 1'b0;
      rd_pend     <= disp_req;
      disp_rvalid <= rd_pend;

      if (disp_req) begin
        mem_en   <= 1'b1;
        mem_addr <= disp_addr;
      end else if (clr_gnt) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= clr_addr;
        mem_wdata <= CLR_COLOR;
      end else if (wr_gnt && wr_in_range) begin
        mem_en    <= 1'b1;
        mem_we    <= 1'b1;
        mem_addr  <= wr_addr;
        mem_wdata <= wr_data;
      end

      case (state)
        IDLE: begin
          if (clr_start) begin
            state    <= CLEAR;
            clr_addr <= '0;
            err_oob  <= 1'b0;
          end
        end
        CLEAR: begin
          if (clr_gnt) begin
            if (clr_addr == LAST_ADDR) begin
              state    <= IDLE;
              clr_addr <= '0;
              clr_done <= 1'b1;
            end else begin
              clr_addr <= clr_addr + ADDR_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      // An out-of-range write still handshakes but only flags the error
      if (wr_gnt && !wr_in_range) err_oob <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fb_arbiter.sv
// tb_fb_arbiter: randomized self-checking bench for fb_arbiter with a RAM model
// and a transaction-level reference model of grants, clear progress and read returns.
module tb_fb_arbiter;

  localparam int unsigned       ADDR_W = 14;
  localparam int unsigned       DATA_W = 24;
  localparam int unsigned       DEPTH  = 10000;
  localparam int unsigned       MEMSZ  = 1 << ADDR_W;
  localparam logic [DATA_W-1:0] CLR    = 24'h000000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_rvalid;
  logic              disp_blank;
  logic              wr_valid;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
  logic              err_oob;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  fb_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_addr(disp_addr), .disp_rdata(disp_rdata),
    .disp_rvalid(disp_rvalid), .disp_blank(disp_blank),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done), .err_oob(err_oob),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Single-port RAM, 1-cycle read latency
  bit [DATA_W-1:0] ram [0:MEMSZ-1];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  // Reference model: framebuffer contents as seen by grant order, clear progress, pending reads
  typedef struct { int due; logic [DATA_W-1:0] data; } rd_t;
  rd_t             rdq[$];
  bit [DATA_W-1:0] ref_mem [0:MEMSZ-1];
  bit              m_busy, m_oob, m_done, m_en, m_we;
  int              m_cnt;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_wdata;

  function automatic bit blank_ok();
`ifdef WR_BLANK_ONLY_EN
    return disp_blank;
`else
    return 1'b1;
`endif
  endfunction

  function automatic bit exp_ready();
    return !m_busy && !disp_req && blank_ok();
  endfunction

  function automatic bit exp_rv();
    return rdq.size() > 0 && rdq[0].due == cyc;
  endfunction

  // Apply this cycle's inputs to the model, then cross the clock edge
  task automatic advance();
    bit was_busy;
    bit oob_wr;
    if (!rst_n) begin
      m_busy = 0; m_cnt = 0; m_oob = 0; m_done = 0; m_en = 0; m_we = 0;
      m_addr = '0; m_wdata = '0;
      rdq.delete();
    end else begin
      was_busy = m_busy;
      oob_wr   = 0;
      m_done = 0; m_en = 0; m_we = 0;
      if (disp_req) begin
        rdq.push_back('{due: cyc + 2, data: ref_mem[disp_addr]});
        m_en = 1; m_addr = disp_addr;
      end else if (was_busy && blank_ok()) begin
        ref_mem[m_cnt] = CLR;
        m_en = 1; m_we = 1; m_addr = ADDR_W'(m_cnt); m_wdata = CLR;
        m_cnt++;
        if (m_cnt == DEPTH) begin m_busy = 0; m_done = 1; end
      end else if (!was_busy && blank_ok() && wr_valid) begin
        if (int'(wr_addr) < int'(DEPTH)) begin
          ref_mem[wr_addr] = wr_data;
          m_en = 1; m_we = 1; m_addr = wr_addr; m_wdata = wr_data;
        end else begin
          oob_wr = 1;
        end
      end
      if (!was_busy && clr_start) begin m_busy = 1; m_cnt = 0; m_oob = 0; end
      if (oob_wr) m_oob = 1;
    end
    @(posedge clk);
    #1;
    cyc++;
    while (rdq.size() > 0 && rdq[0].due < cyc) void'(rdq.pop_front());
  endtask

  task automatic idle_inputs();
    disp_req = 0; disp_addr = '0; disp_blank = 1;
    wr_valid = 0; wr_addr = '0; wr_data = '0; clr_start = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    advance();
    advance();
    @(negedge clk);
    n_chk++; if ({disp_rvalid, mem_en, mem_we, clr_busy, clr_done, err_oob} !== 6'b0) begin
      n_fail++; $display("FAIL reset_flags got %b required 000000", {disp_rvalid, mem_en, mem_we, clr_busy, clr_done, err_oob});
    end
    n_chk++; if (mem_addr !== '0) begin n_fail++; $display("FAIL reset_mem_addr got %h required 0", mem_addr); end
    n_chk++; if (mem_wdata !== '0) begin n_fail++; $display("FAIL reset_mem_wdata got %h required 0", mem_wdata); end
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready got %b required 1", wr_ready); end
    rst_n = 1;
    advance();
  endtask

  task automatic test_read_basic();
    wr_valid = 1; wr_addr = 14'd5; wr_data = 24'hFFFFFF;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL rd_prewrite_ready got %b required 1", wr_ready); end
    advance();
    wr_valid = 0;
    @(negedge clk);
    n_chk++; if ({mem_en, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b1, 14'd5, 24'hFFFFFF}) begin
      n_fail++; $display("FAIL wr_port got en=%b we=%b a=%h d=%h required 1 1 0005 ffffff", mem_en, mem_we, mem_addr, mem_wdata);
    end
    advance();
    disp_req = 1; disp_addr = 14'd5;
    advance();
    disp_req = 0;
    @(negedge clk);
    n_chk++; if ({disp_rvalid, mem_en, mem_we} !== 3'b010) begin
      n_fail++; $display("FAIL rd_n1 got rvalid=%b en=%b we=%b required 0 1 0", disp_rvalid, mem_en, mem_we);
    end
    advance();
    @(negedge clk);
    n_chk++; if (disp_rvalid !== 1'b1 || disp_rdata !== 24'hFFFFFF) begin
      n_fail++; $display("FAIL rd_n2 got rvalid=%b data=%h required 1 ffffff", disp_rvalid, disp_rdata);
    end
    advance();
    @(negedge clk);
    n_chk++; if (disp_rvalid !== 1'b0) begin n_fail++; $display("FAIL rd_single got rvalid=%b required 0", disp_rvalid); end
    advance();
  endtask

  task automatic test_write_stall();
    wr_valid = 1; wr_addr = 14'd10; wr_data = 24'h00FF00;
    for (int i = 0; i < 3; i++) begin
      disp_req = 1; disp_addr = ADDR_W'($urandom % 64);
      @(negedge clk);
      n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL stall_ready[%0d] got %b required 0", i, wr_ready); end
      advance();
    end
    disp_req = 0;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release got %b required 1", wr_ready); end
    advance();
    wr_valid = 0;
    disp_req = 1; disp_addr = 14'd10;
    advance();
    disp_req = 0;
    advance();
    @(negedge clk);
    n_chk++; if (disp_rvalid !== 1'b1 || disp_rdata !== 24'h00FF00) begin
      n_fail++; $display("FAIL stall_readback got rvalid=%b data=%h required 1 00ff00", disp_rvalid, disp_rdata);
    end
    advance();
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      disp_req   = ($urandom % 3) == 0;
      disp_addr  = ADDR_W'($urandom % 64);
      disp_blank = ($urandom % 4) != 0;
      wr_valid   = ($urandom % 2) == 0;
      wr_addr    = (($urandom % 10) == 0) ? ADDR_W'(DEPTH + ($urandom % 300)) : ADDR_W'($urandom % 64);
      if ((i % 500) == 1) wr_addr = ADDR_W'(DEPTH - 1);
      wr_data    = DATA_W'($urandom);
      @(negedge clk);
      n_chk++; if (wr_ready !== exp_ready()) begin n_fail++; $display("FAIL rnd_ready cyc=%0d got %b required %b", cyc, wr_ready, exp_ready()); end
      n_chk++; if (disp_rvalid !== exp_rv()) begin n_fail++; $display("FAIL rnd_rvalid cyc=%0d got %b required %b", cyc, disp_rvalid, exp_rv()); end
      if (exp_rv()) begin
        n_chk++; if (disp_rdata !== rdq[0].data) begin n_fail++; $display("FAIL rnd_rdata cyc=%0d got %h required %h", cyc, disp_rdata, rdq[0].data); end
      end
      n_chk++; if ({mem_en, mem_we, err_oob, clr_busy} !== {m_en, m_we, m_oob, m_busy}) begin
        n_fail++; $display("FAIL rnd_ctrl cyc=%0d got %b required %b", cyc, {mem_en, mem_we, err_oob, clr_busy}, {m_en, m_we, m_oob, m_busy});
      end
      if (m_en) begin
        n_chk++; if (mem_addr !== m_addr) begin n_fail++; $display("FAIL rnd_addr cyc=%0d got %h required %h", cyc, mem_addr, m_addr); end
      end
      if (m_we) begin
        n_chk++; if (mem_wdata !== m_wdata) begin n_fail++; $display("FAIL rnd_wdata cyc=%0d got %h required %h", cyc, mem_wdata, m_wdata); end
      end
      advance();
    end
    idle_inputs();
    advance();
    advance();
  endtask

  task automatic test_oob_clear();
    int busy_cnt = 0;
    int done_cnt = 0;
    int nz = 0;
    wr_valid = 1; wr_addr = 14'd10000; wr_data = 24'h123456;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL oob_ready got %b required 1", wr_ready); end
    advance();
    wr_valid = 0;
    @(negedge clk);
    n_chk++; if (mem_en !== 1'b0 || err_oob !== 1'b1) begin
      n_fail++; $display("FAIL oob_flag got en=%b err=%b required 0 1", mem_en, err_oob);
    end
    for (int i = 0; i < 4; i++) advance();
    @(negedge clk);
    n_chk++; if (err_oob !== 1'b1) begin n_fail++; $display("FAIL oob_sticky got %b required 1", err_oob); end
    clr_start = 1;
    advance();
    clr_start = 0;
    for (int k = 0; k < 10010; k++) begin
      if (k == 5) clr_start = 1;
      if (k == 6) clr_start = 0;
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (err_oob !== 1'b0) begin n_fail++; $display("FAIL oob_cleared got %b required 0", err_oob); end
      end
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      n_chk++; if ({clr_busy, clr_done, mem_en, mem_we} !== {m_busy, m_done, m_en, m_we}) begin
        n_fail++; $display("FAIL clr_ctrl k=%0d got %b required %b", k, {clr_busy, clr_done, mem_en, mem_we}, {m_busy, m_done, m_en, m_we});
      end
      advance();
    end
    n_chk++; if (busy_cnt != int'(DEPTH)) begin n_fail++; $display("FAIL clr_busy_len got %0d required %0d", busy_cnt, DEPTH); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL clr_done_cnt got %0d required 1", done_cnt); end
    for (int a = 0; a < int'(DEPTH); a++) if (ram[a] != CLR) nz++;
    n_chk++; if (nz != 0) begin n_fail++; $display("FAIL clr_ram_dirty got %0d required 0", nz); end
  endtask

  task automatic test_clear_with_reads();
    int busy_cnt = 0;
    int done_cnt = 0;
    int rv_cnt = 0;
    for (int a = 0; a < int'(DEPTH); a++) begin
      wr_valid = 1; wr_addr = ADDR_W'(a); wr_data = DATA_W'(a + 1);
      advance();
    end
    wr_valid = 0;
    clr_start = 1;
    advance();
    clr_start = 0;
    for (int k = 0; k < 20006; k++) begin
      disp_req  = (k < 20000) && ((k % 2) == 0);
      disp_addr = ADDR_W'($urandom % DEPTH);
      @(negedge clk);
      if (clr_busy === 1'b1) busy_cnt++;
      if (clr_done === 1'b1) done_cnt++;
      if (disp_rvalid === 1'b1) rv_cnt++;
      n_chk++; if (disp_rvalid !== exp_rv()) begin n_fail++; $display("FAIL cr_rvalid k=%0d got %b required %b", k, disp_rvalid, exp_rv()); end
      if (exp_rv()) begin
        n_chk++; if (disp_rdata !== rdq[0].data) begin n_fail++; $display("FAIL cr_rdata k=%0d got %h required %h", k, disp_rdata, rdq[0].data); end
      end
      n_chk++; if ({clr_busy, clr_done, mem_en, mem_we} !== {m_busy, m_done, m_en, m_we}) begin
        n_fail++; $display("FAIL cr_ctrl k=%0d got %b required %b", k, {clr_busy, clr_done, mem_en, mem_we}, {m_busy, m_done, m_en, m_we});
      end
      advance();
    end
    n_chk++; if (busy_cnt != 20000) begin n_fail++; $display("FAIL cr_busy_len got %0d required 20000", busy_cnt); end
    n_chk++; if (done_cnt != 1) begin n_fail++; $display("FAIL cr_done_cnt got %0d required 1", done_cnt); end
    n_chk++; if (rv_cnt != 10000) begin n_fail++; $display("FAIL cr_rvalid_cnt got %0d required 10000", rv_cnt); end
    idle_inputs();
  endtask

  task automatic test_reset_during_clear();
    int done_cnt = 0;
    clr_start = 1;
    advance();
    clr_start = 0;
    for (int k = 0; k < 500; k++) advance();
    n_chk++; if (m_cnt != 500 || clr_busy !== 1'b1) begin
      n_fail++; $display("FAIL rc_progress got cnt=%0d busy=%b required 500 1", m_cnt, clr_busy);
    end
    rst_n = 0;
    advance();
    rst_n = 1;
    @(negedge clk);
    n_chk++; if ({clr_busy, clr_done, mem_en} !== 3'b000) begin
      n_fail++; $display("FAIL rc_abort got %b required 000", {clr_busy, clr_done, mem_en});
    end
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (clr_done === 1'b1 || clr_busy === 1'b1) done_cnt++;
      advance();
    end
    n_chk++; if (done_cnt != 0) begin n_fail++; $display("FAIL rc_no_done got %0d required 0", done_cnt); end
  endtask

  task automatic test_blank();
    wr_valid = 1; wr_addr = 14'd20; wr_data = 24'hABCDEF; disp_blank = 0;
    @(negedge clk);
`ifdef WR_BLANK_ONLY_EN
    n_chk++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL blank_low_ready got %b required 0", wr_ready); end
`else
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL blank_ignored_ready got %b required 1", wr_ready); end
`endif
    advance();
    disp_blank = 1;
    @(negedge clk);
    n_chk++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL blank_high_ready got %b required 1", wr_ready); end
    advance();
    idle_inputs();
    @(negedge clk);
    n_chk++; if ({mem_en, mem_we, mem_addr} !== {1'b1, 1'b1, 14'd20}) begin
      n_fail++; $display("FAIL blank_write got en=%b we=%b a=%h required 1 1 0014", mem_en, mem_we, mem_addr);
    end
    advance();
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_stall();
    test_random();
    test_oob_clear();
    test_clear_with_reads();
    test_reset_during_clear();
    test_blank();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
